// File: rtl/vga_timing_generator.sv
// Raster timing generator: free-running h/v counters advanced by a pixel strobe,
// with a one-stage registered sync / data-enable / colour output stage.
module vga_timing_generator #(
    parameter int   H_ACTIVE  = 300,
    parameter int   H_FP      = 9,
    parameter int   H_SYNC    = 46,
    parameter int   H_BP      = 23,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 15,
    parameter int   V_SYNC    = 3,
    parameter int   V_BP      = 35,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   COLOR_W   = 12,
    parameter int   CNT_W     = 11
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [COLOR_W-1:0] i_color,
    output logic [CNT_W-1:0]   o_req_x,
    output logic [CNT_W-1:0]   o_req_y,
    output logic               o_req,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_line_start,
    output logic               o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

    logic [CNT_W-1:0] h_cnt_p0;
    logic [CNT_W-1:0] v_cnt_p0;
    logic             vld_p0;
    logic             h_last_p0;
    logic             v_last_p0;
    logic             vis_p0;
    logic             hs_act_p0;
    logic             vs_act_p0;

    assign vld_p0    = i_enable;
    assign h_last_p0 = (h_cnt_p0 == H_LAST);
    assign v_last_p0 = (v_cnt_p0 == V_LAST);
    assign vis_p0    = (h_cnt_p0 < H_VIS_END) && (v_cnt_p0 < V_VIS_END);
    assign hs_act_p0 = (h_cnt_p0 >= HS_START) && (h_cnt_p0 < HS_END);
    assign vs_act_p0 = (v_cnt_p0 >= VS_START) && (v_cnt_p0 < VS_END);

    assign o_req_x = h_cnt_p0;
    assign o_req_y = v_cnt_p0;
    assign o_req   = vis_p0;

    // Stage p0: position counters, advanced only on pixel strobes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (vld_p0) begin
            if (h_last_p0) begin
                h_cnt_p0 <= '0;
                v_cnt_p0 <= v_last_p0 ? '0 : v_cnt_p0 + 1'b1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 1'b1;
            end
        end
    end

    // Stage p1: registered outputs; pulses are rebuilt every clock so they never stretch
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_de          <= 1'b0;
            o_color       <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_line_start  <= vld_p0 && (h_cnt_p0 == '0);
            o_frame_start <= vld_p0 && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
            if (vld_p0) begin
                o_hsync <= sync_level(hs_act_p0, HSYNC_POL);
                o_vsync <= sync_level(vs_act_p0, VSYNC_POL);
                o_de    <= vis_p0;
                o_color <= vis_p0 ? i_color : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Randomised bench for vga_timing_generator: a default-sized and a tiny
// positive-polarity instance share stimulus and are compared to a pixel-index model.
module tb_vga_timing_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] color = 12'h000;

    always #5 clk = ~clk;

    logic [10:0] a_x, a_y, b_x, b_y;
    logic        a_req, a_hs, a_vs, a_de, a_ls, a_fs;
    logic        b_req, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [11:0] a_col, b_col;

    vga_timing_generator dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_color(color),
        .o_req_x(a_x), .o_req_y(a_y), .o_req(a_req),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_color(a_col),
        .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(12), .CNT_W(11)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_color(color),
        .o_req_x(b_x), .o_req_y(b_y), .o_req(b_req),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_color(b_col),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        logic hp, vp;
    } cfg_t;

    // Model state: number of pixel strobes since reset plus the last registered outputs.
    typedef struct {
        longint      n;
        logic        hs, vs, de, ls, fs;
        logic [11:0] col;
    } mdl_t;

    cfg_t cfg_a, cfg_b;
    mdl_t m_a, m_b;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
    function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
    function automatic longint pos_x(cfg_t c, mdl_t m); return m.n % htot(c); endfunction
    function automatic longint pos_y(cfg_t c, mdl_t m); return (m.n / htot(c)) % vtot(c); endfunction

    function automatic mdl_t mdl_step(cfg_t c, mdl_t m, logic rn, logic e, logic [11:0] pix);
        mdl_t   r = m;
        longint h = pos_x(c, m);
        longint v = pos_y(c, m);
        if (!rn) begin
            r.n = 0; r.hs = ~c.hp; r.vs = ~c.vp; r.de = 1'b0; r.col = '0;
            r.ls = 1'b0; r.fs = 1'b0;
        end else begin
            r.ls = e && (h == 0);
            r.fs = e && (h == 0) && (v == 0);
            if (e) begin
                r.de  = (h < c.ha) && (v < c.va);
                r.col = r.de ? pix : 12'h000;
                r.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
                r.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
                r.n   = m.n + 1;
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic run_cycle(input logic rn, input logic e, input logic [11:0] pix);
        rst_n = rn; en = e; color = pix;
        @(posedge clk);
        m_a = mdl_step(cfg_a, m_a, rn, e, pix);
        m_b = mdl_step(cfg_b, m_b, rn, e, pix);
        #1;
        check_eq("a_req_x", a_x, pos_x(cfg_a, m_a));
        check_eq("a_req_y", a_y, pos_y(cfg_a, m_a));
        check_eq("a_req", a_req, (pos_x(cfg_a, m_a) < cfg_a.ha) && (pos_y(cfg_a, m_a) < cfg_a.va));
        check_eq("a_hsync", a_hs, m_a.hs);
        check_eq("a_vsync", a_vs, m_a.vs);
        check_eq("a_de", a_de, m_a.de);
        check_eq("a_color", a_col, m_a.col);
        check_eq("a_line_start", a_ls, m_a.ls);
        check_eq("a_frame_start", a_fs, m_a.fs);
        check_eq("b_req_x", b_x, pos_x(cfg_b, m_b));
        check_eq("b_req_y", b_y, pos_y(cfg_b, m_b));
        check_eq("b_req", b_req, (pos_x(cfg_b, m_b) < cfg_b.ha) && (pos_y(cfg_b, m_b) < cfg_b.va));
        check_eq("b_hsync", b_hs, m_b.hs);
        check_eq("b_vsync", b_vs, m_b.vs);
        check_eq("b_de", b_de, m_b.de);
        check_eq("b_color", b_col, m_b.col);
        check_eq("b_line_start", b_ls, m_b.ls);
        check_eq("b_frame_start", b_fs, m_b.fs);
    endtask

    initial begin
        cfg_a = '{ha: 300, hf: 9, hs: 46, hb: 23, va: 480, vf: 15, vs: 3, vb: 35, hp: 1'b0, vp: 1'b0};
        cfg_b = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
        m_a = '{n: 0, hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, col: 12'h000};
        m_b = m_a;

        // Reset, then free-running at full rate with a constant colour.
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 12'hABC);
        for (int i = 0; i < 1200; i++) run_cycle(1'b1, 1'b1, 12'hABC);

        // One strobe in four with random colour.
        for (int i = 0; i < 800; i++)
            run_cycle(1'b1, (i % 4) == 0, 12'($urandom_range(0, 4095)));

        // Single-cycle reset in the middle of the default instance's hsync.
        begin
            int guard = 0;
            while ((pos_x(cfg_a, m_a) != 320) && (guard < 500)) begin
                run_cycle(1'b1, 1'b1, 12'h5A5);
                guard++;
            end
            check_eq("reach_mid_hsync", pos_x(cfg_a, m_a), 320);
        end
        run_cycle(1'b0, 1'b1, 12'h5A5);
        for (int i = 0; i < 400; i++) run_cycle(1'b1, 1'b1, 12'h5A5);

        // Random strobes, colours and occasional resets.
        for (int i = 0; i < 2500; i++)
            run_cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
                      12'($urandom_range(0, 4095)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 300; visible clocks per line.
REQ-002 SHALL have parameter H_FP, default 9; horizontal front porch clocks.
REQ-003 SHALL have parameter H_SYNC, default 46; hsync pulse clocks.
REQ-004 SHALL have parameter H_BP, default 23; horizontal back porch clocks.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 15, 3 and 35; vertical timing in lines.
REQ-006 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0; asserted sync level.
REQ-007 SHALL have parameter COLOR_W, default 12; pixel color width ({r,g,b}, 4 bits each).
REQ-008 SHALL have parameter CNT_W, default 11; coordinate and counter width.
REQ-009 SHALL have port i_clk, input, 1; the single clock.
REQ-010 SHALL have port i_rst_n, input, 1; reset, synchronous and active-low.
REQ-011 SHALL have port i_enable, input, 1; pixel-rate advance strobe for clock division.
REQ-012 SHALL have port i_color, input, COLOR_W; pixel data for the requested coordinate.
REQ-013 SHALL have ports o_req_x and o_req_y, output, CNT_W; combinational current hcount and vcount.
REQ-014 SHALL have port o_req, output, 1; combinational flag, current position is visible.
REQ-015 SHALL have ports o_hsync and o_vsync, output, 1; registered sync outputs.
REQ-016 SHALL have port o_de, output, 1; registered data-enable.
REQ-017 SHALL have port o_color, output, COLOR_W; registered pixel out, zero when blanked.
REQ-018 SHALL have ports o_line_start and o_frame_start, output, 1; registered single-cycle pulses.

Function
REQ-019 SHALL hold hcount in 0..H_TOTAL-1 and vcount in 0..V_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is formed the same way.
REQ-020 SHALL advance hcount by 1 only in cycles where i_enable=1; hcount=H_TOTAL-1 SHALL wrap to 0 and advance vcount.
REQ-021 SHALL wrap vcount from V_TOTAL-1 to 0 when hcount wraps on the last line.
REQ-022 SHALL drive o_req=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE; i_color is sampled in the same cycle.
REQ-023 SHALL treat hsync as active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, and vsync as active by the same window on vcount.
REQ-024 SHALL drive the asserted level HSYNC_POL or VSYNC_POL when a sync is active, and its inverse otherwise.
REQ-025 SHALL register o_hsync, o_vsync, o_de and o_color from the current counters and i_color on enabled cycles; outputs lag o_req_x/o_req_y by exactly one enabled cycle.
REQ-026 SHALL force o_color=0 whenever o_de=0.
REQ-027 SHALL hold o_hsync, o_vsync, o_de and o_color when i_enable=0.
REQ-028 SHALL pulse o_line_start for one clock, with o_hsync's one-cycle lag, after an enabled cycle with hcount=0.
REQ-029 SHALL pulse o_frame_start for one clock, with o_hsync's one-cycle lag, after an enabled cycle with hcount=0 and vcount=0; o_line_start SHALL pulse in the same cycle.
REQ-030 SHALL force both pulses to 0 in any cycle that does not follow an enabled cycle.

Reset
REQ-031 SHALL, when i_rst_n=0 at a clock edge, set hcount=0, vcount=0, o_de=0, o_color=0, o_line_start=0 and o_frame_start=0.
REQ-032 SHALL also set o_hsync=~HSYNC_POL and o_vsync=~VSYNC_POL on reset.
REQ-033 SHALL give reset priority over i_enable.
REQ-034 SHALL, on reset mid-frame, restart timing at (0,0) on the first enabled cycle after release, with no partial sync pulse.

Verification
REQ-035 Defaults, i_enable=1, reset released at enabled cycle 0 -> o_frame_start and o_line_start pulse at cycle 1, o_de=1 for cycles 1..300, o_hsync=0 for cycles 310..355, and the line period is 378.
REQ-036 Defaults, full frame -> o_vsync=0 for lines 495..497, o_frame_start period is 201474 cycles, and o_req_y wraps 532->0.
REQ-037 i_color=12'hABC throughout -> o_color=12'hABC only when o_de=1, and 0 in porches and sync.
REQ-038 i_enable high one cycle in four -> all timings scale by 4, outputs hold between strobes, and each pulse lasts one clock.
REQ-039 HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> o_hsync high on hcount 10..11 (+1 lag), o_vsync high on line 5, and idle low.
REQ-040 i_rst_n low for 1 cycle mid-hsync -> o_hsync returns to inactive next clock, and o_frame_start pulses 1 enabled cycle after release.
